multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier.sv | 214 +++++++++++++++++++++
 tb/tb_multiplier.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multiplier.sv
// 32x32 -> 64-bit multiplier built from radix-4 Booth partial products,
// a carry-save reduction tree and a single carry-propagate final adder.
// LATENCY (0..4) selects how many register stages sit between A/B and P:
//   0 : fully combinational
//   1 : operand capture
//   2 : operand capture + sum/carry register after reduction
//   3 : as 2, plus a product register after the final adder
//   4 : as 3, with a second operand capture stage
// SIGNED_MODE selects two's-complement (1) or unsigned (0) operands.
module multiplier #(
    parameter int LATENCY     = 0,
    parameter int SIGNED_MODE = 1
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] P
);

    // Stage counts derived from the total latency.
    localparam int IN_STAGES  = (LATENCY == 0) ? 0 : ((LATENCY == 4) ? 2 : 1);
    localparam bit MID_REG    = (LATENCY >= 2);
    localparam bit OUT_REG    = (LATENCY >= 3);

    // 17 Booth digits cover a 34-bit extended multiplier, which keeps the
    // unsigned case exact (the top digits see zero extension bits).
    localparam int NUM_DIGITS = 17;
    localparam int NUM_ROWS   = NUM_DIGITS + 1;  // plus the negation-correction row

    logic [31:0] core_a;
    logic [31:0] core_b;

    // ------------------------------------------------------------------
    // Operand capture
    // ------------------------------------------------------------------
    if (IN_STAGES == 0) begin : g_no_capture
        assign core_a = A;
        assign core_b = B;

        // Clock and reset do nothing in the purely combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = CLK ^ rst;
    end else begin : g_capture
        logic [31:0] a_in_d [IN_STAGES];
        logic [31:0] a_in_q [IN_STAGES];
        logic [31:0] b_in_d [IN_STAGES];
        logic [31:0] b_in_q [IN_STAGES];

        // Operand shift chain: stage 0 takes the ports, later stages take the previous one.
        always_comb begin
            for (int s = 0; s < IN_STAGES; s++) begin
                if (s == 0) begin
                    a_in_d[s] = A;
                    b_in_d[s] = B;
                end else begin
                    a_in_d[s] = a_in_q[s-1];
                    b_in_d[s] = b_in_q[s-1];
                end
            end
        end

        // Operand capture registers with synchronous clear.
        always_ff @(posedge CLK) begin
            // NOTE: every pipeline register is cleared, not just a valid bit,
            // so nothing in flight can ever leak onto P after a reset.
            if (rst) begin
                for (int s = 0; s < IN_STAGES; s++) begin
                    a_in_q[s] <= '0;
                    b_in_q[s] <= '0;
                end
            end else begin
                for (int s = 0; s < IN_STAGES; s++) begin
                    a_in_q[s] <= a_in_d[s];
                    b_in_q[s] <= b_in_d[s];
                end
            end
        end

        assign core_a = a_in_q[IN_STAGES-1];
        assign core_b = b_in_q[IN_STAGES-1];
    end

    // ------------------------------------------------------------------
    // Booth radix-4 partial-product generation
    // ------------------------------------------------------------------
    logic        a_sign;
    logic        b_sign;
    logic [63:0] a_ext;
    logic [34:0] b_win;       // {ext, ext, B, 0}: overlapping 3-bit Booth windows
    logic [2:0]  booth_trip;
    logic        booth_neg;
    logic [63:0] booth_mag;
    logic [63:0] neg_corr;
    logic [63:0] pp_rows [NUM_ROWS];

    // Recode B into digits in {-2..+2}; each selects 0, A or 2A, inverted when negative.
    always_comb begin
        // NOTE: every variable gets a value before any branch or loop so no
        // path leaves it unassigned, which would otherwise infer a latch.
        a_sign     = (SIGNED_MODE != 0) ? core_a[31] : 1'b0;
        b_sign     = (SIGNED_MODE != 0) ? core_b[31] : 1'b0;
        a_ext      = {{32{a_sign}}, core_a};
        b_win      = {{2{b_sign}}, core_b, 1'b0};
        booth_trip = '0;
        booth_neg  = 1'b0;
        booth_mag  = '0;
        neg_corr   = '0;

        for (int i = 0; i < NUM_DIGITS; i++) begin
            booth_trip = b_win[2*i +: 3];
            // 100, 101 and 110 are the negative digits; 111 is zero.
            booth_neg  = booth_trip[2] & ~(booth_trip[1] & booth_trip[0]);
            case (booth_trip)
                3'b001, 3'b010, 3'b101, 3'b110: booth_mag = a_ext;
                3'b011, 3'b100:                 booth_mag = a_ext << 1;
                default:                        booth_mag = '0;
            endcase
            // -(m << k) == (~m << k) + (1 << k): invert here, add the +1 in the correction row.
            pp_rows[i]     = (booth_mag ^ {64{booth_neg}}) << (2 * i);
            neg_corr[2*i]  = booth_neg;
        end

        pp_rows[NUM_ROWS-1] = neg_corr;
    end

    // ------------------------------------------------------------------
    // Carry-save reduction to a sum/carry pair
    // ------------------------------------------------------------------
    logic [63:0] csa_sum;
    logic [63:0] csa_carry;
    logic [63:0] csa_maj;

    // Fold each row into the running sum/carry pair with a 3:2 compressor.
    always_comb begin
        // NOTE: blocking assignments here model a chain of combinational
        // stages; each line must see the value produced by the line above.
        csa_sum   = pp_rows[0];
        csa_carry = pp_rows[1];
        csa_maj   = '0;
        for (int r = 2; r < NUM_ROWS; r++) begin
            csa_maj   = (csa_sum & csa_carry) | (csa_sum & pp_rows[r]) | (csa_carry & pp_rows[r]);
            csa_sum   = csa_sum ^ csa_carry ^ pp_rows[r];
            csa_carry = {csa_maj[62:0], 1'b0};  // carry out of bit 63 is beyond the product width
        end
    end

    logic [63:0] add_sum;
    logic [63:0] add_carry;

    if (MID_REG) begin : g_mid_reg
        logic [63:0] sum_d;
        logic [63:0] sum_q;
        logic [63:0] carry_d;
        logic [63:0] carry_q;

        // Reduction results feed the mid-pipeline register.
        always_comb begin
            sum_d   = csa_sum;
            carry_d = csa_carry;
        end

        // Register between partial-product reduction and the final add.
        always_ff @(posedge CLK) begin
            if (rst) begin
                sum_q   <= '0;
                carry_q <= '0;
            end else begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end

        assign add_sum   = sum_q;
        assign add_carry = carry_q;
    end else begin : g_no_mid_reg
        assign add_sum   = csa_sum;
        assign add_carry = csa_carry;
    end

    // ------------------------------------------------------------------
    // Final carry-propagate adder and optional output register
    // ------------------------------------------------------------------
    logic [63:0] product;

    // Resolve the redundant sum/carry form into the 64-bit product.
    always_comb begin
        product = add_sum + add_carry;
    end

    if (OUT_REG) begin : g_out_reg
        logic [63:0] p_d;
        logic [63:0] p_q;

        // Next product value for the output register.
        always_comb begin
            p_d = product;
        end

        // Output register after the final adder.
        always_ff @(posedge CLK) begin
            if (rst) begin
                p_q <= '0;
            end else begin
                p_q <= p_d;
            end
        end

        assign P = p_q;
    end else begin : g_no_out_reg
        assign P = product;
    end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier. Eight instances with different
// LATENCY / SIGNED_MODE settings share one operand and reset stream; a
// history-based reference model predicts every output on every cycle.
module tb_multiplier;

    localparam int NUM_DUT     = 8;
    localparam int RAND_CYCLES = 10000;

    logic        clk;
    logic        rst;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [63:0] p_out [NUM_DUT];

    int checks   = 0;
    int failures = 0;

    // Operand/reset values seen at each rising edge, index = edge number.
    logic [31:0] a_hist [$];
    logic [31:0] b_hist [$];
    bit          rst_hist [$];

    // Instance configurations: latency and signedness per index.
    function automatic int lat_of(input int g);
        case (g)
            0, 1:    return 0;
            2, 3:    return 1;
            4:       return 2;
            5, 6:    return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int sgn_of(input int g);
        case (g)
            1, 3, 6: return 0;
            default: return 1;
        endcase
    endfunction

    for (genvar g = 0; g < NUM_DUT; g++) begin : g_dut
        multiplier #(
            .LATENCY    (lat_of(g)),
            .SIGNED_MODE(sgn_of(g))
        ) u_dut (
            .CLK(clk),
            .rst(rst),
            .A  (a_in),
            .B  (b_in),
            .P  (p_out[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact product by plain arithmetic.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input int sgn);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        if (sgn != 0) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Expected P after the latest edge: operands from edge k-lat+1, or 0 if
    // any edge in that window had reset (or lies before the first edge).
    function automatic logic [63:0] expect_p(input int lat, input int sgn);
        int k;
        k = a_hist.size() - 1;
        if (lat == 0) return ref_mul(a_in, b_in, sgn);
        for (int j = k - lat + 1; j <= k; j++) begin
            if (j < 0) return '0;
            if (rst_hist[j]) return '0;
        end
        return ref_mul(a_hist[k-lat+1], b_hist[k-lat+1], sgn);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one operand pair for one clock edge, then check every instance.
    task automatic cycle(input logic [31:0] a, input logic [31:0] b, input bit r);
        a_in = a;
        b_in = b;
        rst  = r;
        @(posedge clk);
        a_hist.push_back(a_in);
        b_hist.push_back(b_in);
        rst_hist.push_back(rst);
        @(negedge clk);
        for (int g = 0; g < NUM_DUT; g++) begin
            check($sformatf("model_lat%0d_sgn%0d", lat_of(g), sgn_of(g)),
                  p_out[g], expect_p(lat_of(g), sgn_of(g)));
        end
    endtask

    logic [31:0] corners [5] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                                 32'h8000_0000, 32'h7FFF_FFFF};

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        rst  = 1'b1;
        a_in = '0;
        b_in = '0;

        // Reset state: every registered instance reads zero.
        repeat (4) cycle(32'd0, 32'd0, 1'b1);
        check("reset_lat4", p_out[7], 64'd0);

        // Combinational directed cases (index 0 signed, index 1 unsigned).
        cycle(32'd3, 32'd4, 1'b0);
        check("l0s_3x4", p_out[0], 64'h0000_0000_0000_000C);
        cycle(32'hFFFF_FFFF, 32'd1, 1'b0);
        check("l0s_m1x1", p_out[0], 64'hFFFF_FFFF_FFFF_FFFF);
        cycle(32'h8000_0000, 32'h8000_0000, 1'b0);
        check("l0s_min_sq", p_out[0], 64'h4000_0000_0000_0000);
        cycle(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        check("l0s_max_sq", p_out[0], 64'h3FFF_FFFF_0000_0001);
        check("l0u_max_sq", p_out[1], 64'h3FFF_FFFF_0000_0001);
        cycle(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("l0s_m1_sq", p_out[0], 64'h0000_0000_0000_0001);
        check("l0u_ff_sq", p_out[1], 64'hFFFF_FFFE_0000_0001);

        // Reset has no effect on the combinational build.
        cycle(32'd6, 32'd7, 1'b1);
        check("l0s_under_rst", p_out[0], 64'd42);
        check("l2_under_rst", p_out[4], 64'd0);

        // Back-to-back pairs through LATENCY=2 (index 4).
        cycle(32'd2, 32'd3, 1'b0);
        cycle(32'd5, 32'd7, 1'b0);
        check("l2_pair0", p_out[4], 64'd6);
        cycle(32'h0001_0000, 32'h0001_0000, 1'b0);
        check("l2_pair1", p_out[4], 64'd35);
        cycle(32'd0, 32'd0, 1'b0);
        check("l2_pair2", p_out[4], 64'h0000_0001_0000_0000);

        // Reset while two products are in flight: neither may appear.
        cycle(32'd9, 32'd9, 1'b0);
        cycle(32'd10, 32'd10, 1'b1);
        check("l2_rst_flush0", p_out[4], 64'd0);
        cycle(32'd12, 32'd12, 1'b0);
        check("l2_rst_flush1", p_out[4], 64'd0);
        cycle(32'd13, 32'd13, 1'b0);
        check("l2_post_rst0", p_out[4], 64'd144);
        cycle(32'd0, 32'd0, 1'b0);
        check("l2_post_rst1", p_out[4], 64'd169);

        // Random regression with occasional resets, checked by the model.
        for (int n = 0; n < RAND_CYCLES; n++) begin
            cycle(pick_operand(), pick_operand(), ($urandom_range(0, 63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
